// File: rtl/serial_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_result_collector_if
// Brief    : Serial-result input strobe plus valid/ready word output bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_result_collector_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overflow;

  // Environment side: result producer, flush source and word consumer
  modport master (
    output clr, bit_in, bit_valid, out_ready,
    input  out_data, out_valid, busy, overflow
  );

  // Collector side
  modport slave (
    input  clr, bit_in, bit_valid, out_ready,
    output out_data, out_valid, busy, overflow
  );
endinterface
`default_nettype wire

// File: rtl/serial_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : serial_result_collector
// Brief    : Packs strobed one-bit results into WIDTH-bit words, with one
//            assembled word buffered behind a valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module serial_result_collector #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rstn,
  serial_result_collector_if.slave sr
);

  localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
  localparam int                 c_IDX_W    = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_TOP  = c_IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0]   r_asm;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_overflow;

  logic               w_slot_free;
  logic               w_full;
  logic               w_xfer;
  logic [c_IDX_W-1:0] w_pos;
  logic [c_IDX_W-1:0] w_idx;

  assign w_slot_free = !r_out_valid || sr.out_ready;
  assign w_full      = (r_cnt == c_CNT_FULL);
  assign w_xfer      = w_full && w_slot_free;

  // A bit arriving while the full word moves out becomes position 0 of the next word
  assign w_pos = w_full ? '0 : r_cnt[c_IDX_W-1:0];

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_idx = w_pos;
    end else begin : g_msb_first
      assign w_idx = c_IDX_TOP - w_pos;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_asm       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (sr.clr) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out_data  <= r_asm;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && sr.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (sr.bit_valid) begin
        if (!w_full) begin
          r_asm[w_idx] <= sr.bit_in;
          r_cnt        <= r_cnt + c_CNT_ONE;
        end else if (w_xfer) begin
          r_asm[w_idx] <= sr.bit_in;
          r_cnt        <= c_CNT_ONE;
        end else begin
          // Both slots occupied: the result is lost and the loss is latched
          r_overflow   <= 1'b1;
        end
      end else if (w_xfer) begin
        r_cnt <= '0;
      end
    end
  end

  assign sr.out_data  = r_out_data;
  assign sr.out_valid = r_out_valid;
  assign sr.busy      = (r_cnt != '0);
  assign sr.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_result_collector
// Brief    : Drives LSB-first and MSB-first collectors in lockstep against a
//            queue-based reference model plus directed expected words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_result_collector;

  localparam int W = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic clr   = 1'b0;
  logic bin   = 1'b0;
  logic bv    = 1'b0;
  logic ready = 1'b0;

  int checks = 0;
  int errors = 0;

  serial_result_collector_if #(.WIDTH(W)) sr_l ();
  serial_result_collector_if #(.WIDTH(W)) sr_m ();

  assign sr_l.clr = clr;  assign sr_l.bit_in = bin;  assign sr_l.bit_valid = bv;  assign sr_l.out_ready = ready;
  assign sr_m.clr = clr;  assign sr_m.bit_in = bin;  assign sr_m.bit_valid = bv;  assign sr_m.out_ready = ready;

  serial_result_collector #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .rstn(rstn), .sr(sr_l));
  serial_result_collector #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .rstn(rstn), .sr(sr_m));

  always #5 clk = ~clk;

  // Reference model: bits of the word being assembled, the output slot, the sticky flag
  bit         pb[$];
  logic [7:0] m_dl = '0;
  logic [7:0] m_dm = '0;
  bit         m_valid = 1'b0;
  bit         m_ovf = 1'b0;
  logic [7:0] acc_q[$];

  function automatic logic [7:0] pack(bit lsb);
    logic [7:0] v = '0;
    for (int i = 0; i < W; i++) begin
      if (lsb) v[i] = pb[i];
      else     v[W-1-i] = pb[i];
    end
    return v;
  endfunction

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk1("l_valid", sr_l.out_valid, m_valid);
    chk1("m_valid", sr_m.out_valid, m_valid);
    chk8("l_data", sr_l.out_data, m_dl);
    chk8("m_data", sr_m.out_data, m_dm);
    chk1("l_busy", sr_l.busy, pb.size() != 0);
    chk1("m_busy", sr_m.busy, pb.size() != 0);
    chk1("l_ovf", sr_l.overflow, m_ovf);
    chk1("m_ovf", sr_m.overflow, m_ovf);
  endtask

  task automatic cycle();
    bit sf;
    bit xfer;
    if (sr_l.out_valid && ready) acc_q.push_back(sr_l.out_data);
    @(posedge clk);
    sf   = !m_valid || ready;
    xfer = (pb.size() == W) && sf;
    if (clr) begin
      pb.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      if (xfer) begin
        m_dl    = pack(1'b1);
        m_dm    = pack(1'b0);
        m_valid = 1'b1;
        pb.delete();
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      if (bv) begin
        if (pb.size() < W) pb.push_back(bin);
        else               m_ovf = 1'b1;
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(logic v, logic b, logic r, logic c);
    bv = v; bin = b; ready = r; clr = c;
    cycle();
  endtask

  task automatic apply_reset();
    bv = 1'b0; clr = 1'b0;
    rstn = 1'b0;
    #1;
    pb.delete();
    m_valid = 1'b0; m_ovf = 1'b0; m_dl = '0; m_dm = '0;
    compare_all();
    chk8("rst_data", sr_l.out_data, 8'h00);
    chk1("rst_busy", sr_l.busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    bit         t1[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bit         w4[16];
    bit         bits6[$];
    logic [7:0] e2;
    logic [7:0] a5;
    logic [7:0] ew;

    #1;
    apply_reset();

    // T1/T2: same stream, both bit orders
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, t1[i], 1'b1, 1'b0);
      chk1("T2_busy", sr_m.busy, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk1("T1_valid", sr_l.out_valid, 1'b1);
    chk8("T1_data", sr_l.out_data, 8'h4D);
    chk8("T2_data", sr_m.out_data, 8'hB2);
    chk1("T2_busy_end", sr_m.busy, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk1("T1_pulse", sr_l.out_valid, 1'b0);

    // T3: no backpressure relief, 17th bit dropped
    for (int i = 0; i < 17; i++) drive(1'b1, logic'(i < 16), 1'b0, 1'b0);
    chk8("T3_data", sr_l.out_data, 8'hFF);
    chk1("T3_valid", sr_l.out_valid, 1'b1);
    chk1("T3_busy", sr_l.busy, 1'b1);
    chk1("T3_ovf", sr_l.overflow, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk1("T3_second_valid", sr_l.out_valid, 1'b1);
    chk8("T3_second_data", sr_m.out_data, 8'hFF);
    chk1("T3_ovf_sticky", sr_l.overflow, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk1("T3_drained", sr_l.out_valid, 1'b0);
    chk1("T3_ovf_hold", sr_m.overflow, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk1("T3_clr_ovf", sr_l.overflow, 1'b0);

    // T4: bit arriving on the very cycle the full word is released
    for (int i = 0; i < 16; i++) begin
      w4[i] = bit'($urandom_range(0, 1));
      drive(1'b1, w4[i], 1'b0, 1'b0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) e2[i] = w4[8+i];
    chk8("T4_data", sr_l.out_data, e2);
    chk1("T4_busy", sr_l.busy, 1'b1);
    chk1("T4_ovf", sr_l.overflow, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // T5: reset in the middle of a word
    for (int i = 0; i < 5; i++) drive(1'b1, logic'($urandom_range(0, 1)), 1'b1, 1'b0);
    apply_reset();
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) drive(1'b1, a5[i], 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk1("T5_valid", sr_l.out_valid, 1'b1);
    chk8("T5_data_l", sr_l.out_data, 8'hA5);
    chk8("T5_data_m", sr_m.out_data, 8'hA5);

    // T6: sparse producer, mostly-ready consumer
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    acc_q.delete();
    for (int r = 0; r < 40; r++) begin
      bits6.push_back(bit'($urandom_range(0, 1)));
      drive(1'b1, bits6[r], logic'($urandom_range(0, 3) != 0), 1'b0);
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, logic'($urandom_range(0, 3) != 0), 1'b0);
    end
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk8("T6_count", 8'(acc_q.size()), 8'd5);
    for (int wi = 0; wi < 5; wi++) begin
      for (int b = 0; b < 8; b++) ew[b] = bits6[8*wi + b];
      chk8("T6_word", (wi < acc_q.size()) ? acc_q[wi] : 8'hxx, ew);
    end
    chk1("T6_ovf", sr_l.overflow, 1'b0);

    // Random pressure with occasional flushes, fully model-checked
    for (int n = 0; n < 400; n++) begin
      drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
